// File: rtl/al_const_capture_if.sv
// Auto-load constant capture bus: sequencer read strobes in, active-constant read port and load status out.
interface al_const_capture_if;
  logic        AL_START;
  logic        AL_ABORT;
  logic        RD_DATA_VLD;
  logic [5:0]  RD_IDX;
  logic [15:0] RD_DATA;
  logic [5:0]  HOST_IDX;
  logic [15:0] HOST_DATA;
  logic        CONST_VALID;
  logic        COMMIT;
  logic [4:0]  LOAD_STATUS;
  logic [15:0] CKSUM;
  logic [5:0]  WORD_CNT;

  modport master (
    output AL_START, AL_ABORT, RD_DATA_VLD, RD_IDX, RD_DATA, HOST_IDX,
    input  HOST_DATA, CONST_VALID, COMMIT, LOAD_STATUS, CKSUM, WORD_CNT
  );

  modport slave (
    input  AL_START, AL_ABORT, RD_DATA_VLD, RD_IDX, RD_DATA, HOST_IDX,
    output HOST_DATA, CONST_VALID, COMMIT, LOAD_STATUS, CKSUM, WORD_CNT
  );
endinterface

// File: rtl/al_const_capture.sv
// Captures the last-parameter-block auto-load into a shadow file, verifies magic (and checksum when
// AL_CONST_CKSUM_EN is defined) and commits the whole set atomically to the active constant registers.
module al_const_capture #(
  parameter int          NWORDS = 34,
  parameter logic [15:0] MAGIC  = 16'hDCFE
) (
  input logic              CLK,
  input logic              RST,
  al_const_capture_if.slave bus
);
  localparam int DATA_W = 16;
  localparam int IDX_W  = 6;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);
  localparam logic [IDX_W-1:0] CNT_MAX  = IDX_W'(NWORDS);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CAPTURE = 3'd1;
  localparam logic [2:0] S_CHECK   = 3'd2;
  localparam logic [2:0] S_COMMIT  = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;
  localparam logic [2:0] S_ERR     = 3'd5;

  logic [2:0]        state;
  logic [DATA_W-1:0] shadow [NWORDS];
  logic [DATA_W-1:0] active [NWORDS];
  logic [DATA_W-1:0] cksum;
  logic [IDX_W-1:0]  word_cnt;
  logic              st_abort;
  logic              st_seq_err;
  logic              st_magic_err;
  logic              st_cksum_err;
  logic              st_done;
  logic              const_valid;
  logic              commit_p1;
  logic [DATA_W-1:0] host_data_p1;

  logic              magic_bad;
  logic              cksum_bad;
  logic              in_order;

  function automatic logic [DATA_W-1:0] wrap_add(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    return a + b;
  endfunction

  function automatic logic [IDX_W-1:0] sat_inc(input logic [IDX_W-1:0] c);
    return (c >= CNT_MAX) ? CNT_MAX : c + IDX_W'(1);
  endfunction

  assign magic_bad = (shadow[0] != MAGIC);
  assign in_order  = (bus.RD_IDX == word_cnt);

`ifdef AL_CONST_CKSUM_EN
  // The last word is the two's complement of the others, so a clean load sums to zero.
  assign cksum_bad = (cksum != '0);
`else
  assign cksum_bad = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= S_IDLE;
      cksum        <= '0;
      word_cnt     <= '0;
      st_abort     <= 1'b0;
      st_seq_err   <= 1'b0;
      st_magic_err <= 1'b0;
      st_cksum_err <= 1'b0;
      st_done      <= 1'b0;
      const_valid  <= 1'b0;
      commit_p1    <= 1'b0;
      for (int i = 0; i < NWORDS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      commit_p1 <= 1'b0;
      // A restart wins over everything, even a pending check or commit; a coincident strobe is lost.
      if (bus.AL_START) begin
        state        <= S_CAPTURE;
        cksum        <= '0;
        word_cnt     <= '0;
        st_abort     <= 1'b0;
        st_seq_err   <= 1'b0;
        st_magic_err <= 1'b0;
        st_cksum_err <= 1'b0;
        st_done      <= 1'b0;
      end else begin
        case (state)
          S_CAPTURE: begin
            if (bus.AL_ABORT) begin
              st_abort <= 1'b1;
              st_done  <= 1'b1;
              state    <= S_ERR;
            end else if (bus.RD_DATA_VLD) begin
              if (in_order) begin
                shadow[bus.RD_IDX] <= bus.RD_DATA;
                cksum              <= wrap_add(cksum, bus.RD_DATA);
                word_cnt           <= sat_inc(word_cnt);
                if (bus.RD_IDX == LAST_IDX) state <= S_CHECK;
              end else begin
                st_seq_err <= 1'b1;
                st_done    <= 1'b1;
                state      <= S_ERR;
              end
            end
          end
          S_CHECK: begin
            st_magic_err <= magic_bad;
            st_cksum_err <= cksum_bad;
            if (magic_bad || cksum_bad) begin
              st_done <= 1'b1;
              state   <= S_ERR;
            end else begin
              state <= S_COMMIT;
            end
          end
          // Whole shadow file moves in one edge so consumers never see a mixed set.
          S_COMMIT: begin
            for (int i = 0; i < NWORDS; i++) active[i] <= shadow[i];
            commit_p1   <= 1'b1;
            const_valid <= 1'b1;
            st_done     <= 1'b1;
            state       <= S_DONE;
          end
          default: ;
        endcase
      end
    end
  end

  // Registered host read port
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      host_data_p1 <= '0;
    end else begin
      host_data_p1 <= (bus.HOST_IDX < CNT_MAX) ? active[bus.HOST_IDX] : '0;
    end
  end

  assign bus.HOST_DATA   = host_data_p1;
  assign bus.CONST_VALID = const_valid;
  assign bus.COMMIT      = commit_p1;
  assign bus.LOAD_STATUS = {st_abort, st_seq_err, st_magic_err, st_cksum_err, st_done};
  assign bus.CKSUM       = cksum;
  assign bus.WORD_CNT    = word_cnt;
endmodule

// File: doc/al_const_capture.md
Name: al_const_capture

Overview:
- Consumes flash read data returned during the BPI auto-load of the last parameter block (base 0x7FC000): one 16-bit word per index 0..NWORDS-1.
- Collects the words into a shadow register file and verifies a signature word and a checksum word.
- Commits the shadow set atomically to the active constant registers only on a clean load.
- Sits downstream of the auto-load sequencer and BPI read path; feeds constant consumers through a registered read port.

Parameters:
- NWORDS, 34: words per auto-load; indices 0..NWORDS-1 (sequencer runs to MAX_ADDR 33).
- MAGIC, 16'hDCFE: required value of word 0.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset.
- AL_START  in  1  one-cycle pulse; begins a new capture.
- AL_ABORT  in  1  one-cycle pulse; sequencer aborted the load.
- RD_DATA_VLD  in  1  one-cycle strobe; RD_IDX and RD_DATA are valid this cycle.
- RD_IDX  in  6  word index (sequencer AL_CNT).
- RD_DATA  in  16  flash read word.
- HOST_IDX  in  6  active register select.
- HOST_DATA  out  16  active[HOST_IDX], registered.
- CONST_VALID  out  1  active set holds a verified load.
- COMMIT  out  1  one-cycle pulse when active registers are updated.
- LOAD_STATUS  out  5  {abort, seq_err, magic_err, cksum_err, done}.
- CKSUM  out  16  running mod-2^16 sum of captured words.
- WORD_CNT  out  6  words accepted in the current load.

Behaviour:
- Interface: reset RST, asynchronous, active-high; clock CLK.
- Reset values:
  - All outputs 0.
  - Shadow and active registers all 0.
  - State IDLE.
- State machine, states IDLE, CAPTURE, CHECK, COMMIT, DONE, ERR:
  - IDLE/DONE/ERR + AL_START -> CAPTURE.
    - Clears WORD_CNT, CKSUM and LOAD_STATUS.
    - Does NOT clear active registers or CONST_VALID.
  - CAPTURE + RD_DATA_VLD, RD_IDX == WORD_CNT:
    - shadow[RD_IDX] <= RD_DATA; CKSUM += RD_DATA; WORD_CNT++.
    - If RD_IDX == NWORDS-1, go to CHECK next cycle.
  - CAPTURE + RD_DATA_VLD, RD_IDX != WORD_CNT (out of order, duplicate, or >= NWORDS): set seq_err, word discarded, go to ERR.
  - CAPTURE + AL_ABORT: set abort, go to ERR. A strobe in the same cycle is discarded.
  - CHECK (1 cycle):
    - magic_err = (shadow[0] != MAGIC).
    - cksum_err = (CKSUM != 0). Word NWORDS-1 is the two's-complement checksum of words 0..NWORDS-2.
    - Any error -> ERR; else -> COMMIT.
  - COMMIT (1 cycle): all shadow words copied to active in the same edge; COMMIT pulses; CONST_VALID <= 1; -> DONE.
  - DONE: done = 1.
  - ERR: done = 1 and at least one error bit set. Active registers and CONST_VALID unchanged, so a failed reload keeps the last good set.
- AL_START has priority over every other input in any state, including mid-CAPTURE (restart). A coincident strobe is dropped.
- RD_DATA_VLD and AL_ABORT are ignored outside CAPTURE.
- Latency:
  - Last word strobe at edge N.
  - CHECK at N+1.
  - COMMIT pulse and CONST_VALID high at N+2; active data visible the same cycle.
  - HOST_DATA = active[HOST_IDX] one cycle after HOST_IDX is presented.
  - HOST_IDX >= NWORDS returns 16'h0000.
- Arithmetic: CKSUM wraps mod 2^16, no carry out. WORD_CNT saturates at NWORDS.
- RST mid-operation returns everything to reset values, including active and CONST_VALID.

Optional Feature:
- Macro: AL_CONST_CKSUM_EN.
- Defined: checksum check as above; cksum_err is reported.
- Undefined:
  - CHECK evaluates magic only.
  - cksum_err is tied 0.
  - CKSUM output still counts, for debug.
  - Word NWORDS-1 is stored as ordinary data.

Test Plan:
1. Clean load.
   - Stimulus: AL_START, then indices 0..33 in order. Word0 = 0xDCFE, words 1..32 = 0x0001..0x0020, word33 = two's complement of the sum.
   - Response: CKSUM = 0; COMMIT pulses 2 cycles after word 33; CONST_VALID = 1; LOAD_STATUS = 5'b00001; HOST_IDX = 5 gives 0x0005.
2. Bad magic.
   - Stimulus: word0 = 0x1234, checksum consistent.
   - Response: LOAD_STATUS = 5'b00101; no COMMIT; active registers keep the prior set.
3. Checksum failure.
   - Stimulus: clean load after scenario 1 with word 10 corrupted to 0xFFFF.
   - Response: LOAD_STATUS = 5'b00011; CONST_VALID stays 1; HOST_IDX = 10 still returns 0x000A.
4. Sequence error and abort.
   - Stimulus: skip index 7 (send 8 after 6).
   - Response: seq_err, WORD_CNT = 7, ERR.
   - Stimulus: separate run, AL_ABORT after 12 words.
   - Response: LOAD_STATUS = 5'b10001.
5. Priority and reset.
   - Stimulus: AL_START coincident with a strobe at index 20 mid-load.
   - Response: WORD_CNT = 0, data dropped.
   - Stimulus: RST asserted mid-CAPTURE.
   - Response: CONST_VALID = 0 and HOST_DATA = 0 immediately (asynchronous).
6. Feature off (AL_CONST_CKSUM_EN undefined).
   - Stimulus: scenario 3 stimulus.
   - Response: commits; LOAD_STATUS = 5'b00001; HOST_IDX = 10 returns 0xFFFF.
